// File: rtl/rx_chmod_integ_dump.sv
// Integrate-and-dump decimator for channel-modulator I/Q samples.
// Sums 2^k samples per window and emits the rounded mean two cycles later.
module rx_chmod_integ_dump #(
    parameter int WIDTH          = 16,
    parameter int MAX_LOG2_DECIM = 4
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic signed [WIDTH-1:0] i_inph,
    input  logic signed [WIDTH-1:0] i_quad,
    input  logic                    i_inph_oflow,
    input  logic                    i_quad_oflow,
    input  logic                    i_valid,
    input  logic [2:0]              i_log2_decim,
    input  logic                    i_log2_decim_valid,
    output logic signed [WIDTH-1:0] o_inph,
    output logic signed [WIDTH-1:0] o_quad,
    output logic                    o_inph_oflow,
    output logic                    o_quad_oflow,
    output logic                    o_valid
);

    localparam int AW   = WIDTH + MAX_LOG2_DECIM;
    localparam int CW   = MAX_LOG2_DECIM;
    localparam int KCAP = (MAX_LOG2_DECIM > 7) ? 7 : MAX_LOG2_DECIM;
    localparam logic [2:0] KMAX = 3'(KCAP);

    logic [2:0]           k;
    logic [CW-1:0]        cnt;
    logic signed [AW-1:0] acc_i;
    logic signed [AW-1:0] acc_q;
    logic                 sticky_i;
    logic                 sticky_q;

    logic                 a_valid;
    logic [2:0]           a_k;
    logic signed [AW-1:0] a_i;
    logic signed [AW-1:0] a_q;
    logic                 a_oi;
    logic                 a_oq;

    logic [2:0]           k_eff;
    logic [CW-1:0]        base_cnt;
    logic [CW-1:0]        last_idx;
    logic signed [AW-1:0] base_i;
    logic signed [AW-1:0] base_q;
    logic                 base_si;
    logic                 base_sq;
    logic signed [AW-1:0] sum_i;
    logic signed [AW-1:0] sum_q;
    logic                 is_last;

    logic signed [AW-1:0] half;
    logic signed [AW-1:0] rnd_i;
    logic signed [AW-1:0] rnd_q;

    // A config load discards the partial window, so the incoming sample
    // (if any) becomes sample 0 under the new exponent.
    always_comb begin
        k_eff    = k;
        base_cnt = cnt;
        base_i   = acc_i;
        base_q   = acc_q;
        base_si  = sticky_i;
        base_sq  = sticky_q;
        if (i_log2_decim_valid) begin
            k_eff    = (i_log2_decim > KMAX) ? KMAX : i_log2_decim;
            base_cnt = '0;
            base_i   = '0;
            base_q   = '0;
            base_si  = 1'b0;
            base_sq  = 1'b0;
        end
        sum_i    = base_i + {{CW{i_inph[WIDTH-1]}}, i_inph};
        sum_q    = base_q + {{CW{i_quad[WIDTH-1]}}, i_quad};
        last_idx = (CW'(1) << k_eff) - CW'(1);
        is_last  = i_valid && (base_cnt == last_idx);
    end

    // Window accumulation and hand-off of completed sums into stage A.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            k        <= '0;
            cnt      <= '0;
            acc_i    <= '0;
            acc_q    <= '0;
            sticky_i <= 1'b0;
            sticky_q <= 1'b0;
            a_valid  <= 1'b0;
            a_k      <= '0;
            a_i      <= '0;
            a_q      <= '0;
            a_oi     <= 1'b0;
            a_oq     <= 1'b0;
        end else begin
            k       <= k_eff;
            a_valid <= is_last;
            if (is_last) begin
                a_i      <= sum_i;
                a_q      <= sum_q;
                a_k      <= k_eff;
                a_oi     <= base_si | i_inph_oflow;
                a_oq     <= base_sq | i_quad_oflow;
                acc_i    <= '0;
                acc_q    <= '0;
                cnt      <= '0;
                sticky_i <= 1'b0;
                sticky_q <= 1'b0;
            end else if (i_valid) begin
                acc_i    <= sum_i;
                acc_q    <= sum_q;
                cnt      <= base_cnt + CW'(1);
                sticky_i <= base_si | i_inph_oflow;
                sticky_q <= base_sq | i_quad_oflow;
            end else begin
                acc_i    <= base_i;
                acc_q    <= base_q;
                cnt      <= base_cnt;
                sticky_i <= base_si;
                sticky_q <= base_sq;
            end
        end
    end

    // Round-half-up bias uses the exponent captured with the stage A sum.
    always_comb begin
        half = '0;
        if (a_k != 3'd0) begin
            half = {{(AW-1){1'b0}}, 1'b1} << (a_k - 3'd1);
        end
        rnd_i = a_i + half;
        rnd_q = a_q + half;
    end

    // Output register: updates only on a stage A result, holds otherwise.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_inph       <= '0;
            o_quad       <= '0;
            o_inph_oflow <= 1'b0;
            o_quad_oflow <= 1'b0;
            o_valid      <= 1'b0;
        end else begin
            o_valid <= a_valid;
            if (a_valid) begin
                o_inph       <= WIDTH'(rnd_i >>> a_k);
                o_quad       <= WIDTH'(rnd_q >>> a_k);
                o_inph_oflow <= a_oi;
                o_quad_oflow <= a_oq;
            end
        end
    end

endmodule

// File: tb/tb_rx_chmod_integ_dump.sv
// Directed testbench for rx_chmod_integ_dump.
// Inputs change and outputs are sampled on the falling edge.
module tb_rx_chmod_integ_dump;

    localparam int W = 16;

    logic                i_clock = 1'b0;
    logic                i_reset;
    logic signed [W-1:0] i_inph;
    logic signed [W-1:0] i_quad;
    logic                i_inph_oflow;
    logic                i_quad_oflow;
    logic                i_valid;
    logic [2:0]          i_log2_decim;
    logic                i_log2_decim_valid;
    logic signed [W-1:0] o_inph;
    logic signed [W-1:0] o_quad;
    logic                o_inph_oflow;
    logic                o_quad_oflow;
    logic                o_valid;

    int nvec = 0;
    int nerr = 0;
    int pulses = 0;

    rx_chmod_integ_dump #(.WIDTH(W), .MAX_LOG2_DECIM(4)) dut (
        .i_clock(i_clock),
        .i_reset(i_reset),
        .i_inph(i_inph),
        .i_quad(i_quad),
        .i_inph_oflow(i_inph_oflow),
        .i_quad_oflow(i_quad_oflow),
        .i_valid(i_valid),
        .i_log2_decim(i_log2_decim),
        .i_log2_decim_valid(i_log2_decim_valid),
        .o_inph(o_inph),
        .o_quad(o_quad),
        .o_inph_oflow(o_inph_oflow),
        .o_quad_oflow(o_quad_oflow),
        .o_valid(o_valid)
    );

    always #5 i_clock = ~i_clock;

    always @(posedge i_clock) if (o_valid) pulses <= pulses + 1;

    task automatic step();
        @(negedge i_clock);
    endtask

    task automatic put(input bit v, input int iv, input int qv,
                       input bit io = 1'b0, input bit qo = 1'b0);
        i_valid      = v;
        i_inph       = W'(iv);
        i_quad       = W'(qv);
        i_inph_oflow = io;
        i_quad_oflow = qo;
        step();
    endtask

    task automatic idle();
        put(1'b0, 0, 0);
    endtask

    task automatic cfg(input int kv);
        i_valid            = 1'b0;
        i_log2_decim       = 3'(kv);
        i_log2_decim_valid = 1'b1;
        step();
        i_log2_decim_valid = 1'b0;
    endtask

    task automatic test_reset();
        nvec++;
        if (o_valid !== 1'b0) begin
            nerr++; $display("FAIL reset_valid got %0b want 0", o_valid);
        end
        nvec++;
        if (o_inph !== 16'sd0 || o_quad !== 16'sd0) begin
            nerr++; $display("FAIL reset_data got %0d/%0d want 0/0", o_inph, o_quad);
        end
        nvec++;
        if (o_inph_oflow !== 1'b0 || o_quad_oflow !== 1'b0) begin
            nerr++; $display("FAIL reset_oflow got %0b/%0b want 0/0",
                             o_inph_oflow, o_quad_oflow);
        end
    endtask

    task automatic test_k0();
        put(1'b1, -5, 7);
        idle();
        nvec++;
        if (o_valid !== 1'b1 || o_inph !== -16'sd5 || o_quad !== 16'sd7) begin
            nerr++; $display("FAIL k0_pass got v=%0b %0d/%0d want v=1 -5/7",
                             o_valid, o_inph, o_quad);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        put(1'b1, 1, -1);
        put(1'b1, 2, -2);
        nvec++;
        if (o_valid !== 1'b1 || o_inph !== 16'sd1) begin
            nerr++; $display("FAIL b2b_0 got v=%0b %0d want v=1 1", o_valid, o_inph);
        end
        put(1'b1, 3, -3);
        nvec++;
        if (o_valid !== 1'b1 || o_inph !== 16'sd2) begin
            nerr++; $display("FAIL b2b_1 got v=%0b %0d want v=1 2", o_valid, o_inph);
        end
        idle();
        nvec++;
        if (o_valid !== 1'b1 || o_inph !== 16'sd3 || o_quad !== -16'sd3) begin
            nerr++; $display("FAIL b2b_2 got v=%0b %0d/%0d want v=1 3/-3",
                             o_valid, o_inph, o_quad);
        end
        idle();
        nvec++;
        if (o_valid !== 1'b0) begin
            nerr++; $display("FAIL b2b_end got v=%0b want 0", o_valid);
        end
    endtask

    task automatic test_avg();
        int p0;
        cfg(2);
        p0 = pulses;
        put(1'b1, 100, -1);
        put(1'b1, 101, -2);
        put(1'b1, 102, -3);
        put(1'b1, 103, -4);
        nvec++;
        if (o_valid !== 1'b0) begin
            nerr++; $display("FAIL avg_early got v=%0b want 0", o_valid);
        end
        idle();
        nvec++;
        if (o_valid !== 1'b1 || o_inph !== 16'sd102 || o_quad !== -16'sd2) begin
            nerr++; $display("FAIL avg_k2 got v=%0b %0d/%0d want v=1 102/-2",
                             o_valid, o_inph, o_quad);
        end
        idle();
        nvec++;
        if (o_valid !== 1'b0 || o_inph !== 16'sd102 || o_quad !== -16'sd2) begin
            nerr++; $display("FAIL avg_hold got v=%0b %0d/%0d want v=0 102/-2",
                             o_valid, o_inph, o_quad);
        end
        idle();
        nvec++;
        if (pulses - p0 !== 1) begin
            nerr++; $display("FAIL avg_count got %0d want 1", pulses - p0);
        end
    endtask

    task automatic test_gaps();
        int p0;
        cfg(4);
        p0 = pulses;
        for (int n = 0; n < 16; n++) begin
            put(1'b1, -32768, 32767);
            put(1'b0, 0, 0);
        end
        nvec++;
        if (o_valid !== 1'b1 || o_inph !== -16'sd32768 || o_quad !== 16'sd32767) begin
            nerr++; $display("FAIL gaps_k4 got v=%0b %0d/%0d want v=1 -32768/32767",
                             o_valid, o_inph, o_quad);
        end
        idle();
        idle();
        nvec++;
        if (pulses - p0 !== 1) begin
            nerr++; $display("FAIL gaps_count got %0d want 1", pulses - p0);
        end
    endtask

    task automatic test_oflow();
        cfg(2);
        put(1'b1, 0, 0);
        put(1'b1, 0, 0, 1'b1, 1'b0);
        put(1'b1, 0, 0);
        put(1'b1, 0, 0);
        idle();
        nvec++;
        if (o_valid !== 1'b1 || o_inph_oflow !== 1'b1 || o_quad_oflow !== 1'b0) begin
            nerr++; $display("FAIL oflow_set got v=%0b %0b/%0b want v=1 1/0",
                             o_valid, o_inph_oflow, o_quad_oflow);
        end
        for (int n = 0; n < 4; n++) put(1'b1, 0, 0);
        idle();
        nvec++;
        if (o_valid !== 1'b1 || o_inph_oflow !== 1'b0 || o_quad_oflow !== 1'b0) begin
            nerr++; $display("FAIL oflow_clear got v=%0b %0b/%0b want v=1 0/0",
                             o_valid, o_inph_oflow, o_quad_oflow);
        end
        idle();
    endtask

    task automatic test_clamp();
        cfg(6);
        for (int n = 0; n < 16; n++) put(1'b1, 5, -5);
        idle();
        nvec++;
        if (o_valid !== 1'b1 || o_inph !== 16'sd5 || o_quad !== -16'sd5) begin
            nerr++; $display("FAIL clamp_k got v=%0b %0d/%0d want v=1 5/-5",
                             o_valid, o_inph, o_quad);
        end
        idle();
    endtask

    task automatic test_reconfig();
        int p0;
        cfg(2);
        p0 = pulses;
        put(1'b1, 1, 0);
        put(1'b1, 2, 0);
        i_log2_decim       = 3'd1;
        i_log2_decim_valid = 1'b1;
        put(1'b1, 10, 0);
        i_log2_decim_valid = 1'b0;
        put(1'b1, 20, 0);
        idle();
        nvec++;
        if (o_valid !== 1'b1 || o_inph !== 16'sd15) begin
            nerr++; $display("FAIL reconfig got v=%0b %0d want v=1 15", o_valid, o_inph);
        end
        idle();
        idle();
        nvec++;
        if (pulses - p0 !== 1) begin
            nerr++; $display("FAIL reconfig_count got %0d want 1", pulses - p0);
        end
    endtask

    task automatic test_stage_a();
        put(1'b1, 8, 0);
        put(1'b1, 9, 0);
        i_log2_decim       = 3'd0;
        i_log2_decim_valid = 1'b1;
        put(1'b1, -3, 0);
        i_log2_decim_valid = 1'b0;
        nvec++;
        if (o_valid !== 1'b1 || o_inph !== 16'sd9) begin
            nerr++; $display("FAIL stagea_old got v=%0b %0d want v=1 9", o_valid, o_inph);
        end
        idle();
        nvec++;
        if (o_valid !== 1'b1 || o_inph !== -16'sd3) begin
            nerr++; $display("FAIL stagea_new got v=%0b %0d want v=1 -3", o_valid, o_inph);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        int p0;
        cfg(1);
        p0 = pulses;
        put(1'b1, 100, 0);
        i_valid = 1'b0;
        i_reset = 1'b1;
        #1;
        nvec++;
        if (o_valid !== 1'b0 || o_inph !== 16'sd0) begin
            nerr++; $display("FAIL rst_mid_clear got v=%0b %0d want v=0 0", o_valid, o_inph);
        end
        step();
        i_reset = 1'b0;
        put(1'b1, 4, 0);
        put(1'b1, 6, 0);
        nvec++;
        if (o_valid !== 1'b1 || o_inph !== 16'sd4) begin
            nerr++; $display("FAIL rst_mid_first got v=%0b %0d want v=1 4", o_valid, o_inph);
        end
        idle();
        nvec++;
        if (o_valid !== 1'b1 || o_inph !== 16'sd6) begin
            nerr++; $display("FAIL rst_mid_second got v=%0b %0d want v=1 6", o_valid, o_inph);
        end
        idle();
        idle();
        nvec++;
        if (pulses - p0 !== 2) begin
            nerr++; $display("FAIL rst_mid_count got %0d want 2", pulses - p0);
        end
    endtask

    initial begin
        i_reset            = 1'b1;
        i_inph             = '0;
        i_quad             = '0;
        i_inph_oflow       = 1'b0;
        i_quad_oflow       = 1'b0;
        i_valid            = 1'b0;
        i_log2_decim       = '0;
        i_log2_decim_valid = 1'b0;
        step();
        step();
        test_reset();
        i_reset = 1'b0;
        step();
        test_k0();
        test_back_to_back();
        test_avg();
        test_gaps();
        test_oflow();
        test_clamp();
        test_reconfig();
        test_stage_a();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/rx_chmod_integ_dump.md
RX_CHMOD_INTEG_DUMP -- requirements
Module: rx_chmod_integ_dump

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: signed I/Q sample width.
REQ-002 The block SHALL have parameter MAX_LOG2_DECIM, default 4: largest supported log2 decimation factor.
REQ-003 Port i_clock, input, 1: the only clock; all logic SHALL be rising-edge.
REQ-004 Port i_reset, input, 1: asynchronous, active-high reset.
REQ-005 Port i_inph, input, WIDTH: signed in-phase sample from the channel modulator.
REQ-006 Port i_quad, input, WIDTH: signed quadrature sample.
REQ-007 Port i_inph_oflow, input, 1: upstream I overflow flag, qualified by i_valid.
REQ-008 Port i_quad_oflow, input, 1: upstream Q overflow flag, qualified by i_valid.
REQ-009 Port i_valid, input, 1: sample strobe; gaps SHALL be allowed.
REQ-010 Port i_log2_decim, input, 3: requested decimation exponent k.
REQ-011 Port i_log2_decim_valid, input, 1: single-cycle configuration load strobe.
REQ-012 Port o_inph, output, WIDTH: signed decimated I.
REQ-013 Port o_quad, output, WIDTH: signed decimated Q.
REQ-014 Port o_inph_oflow, output, 1: I window overflow flag.
REQ-015 Port o_quad_oflow, output, 1: Q window overflow flag.
REQ-016 Port o_valid, output, 1: single-cycle output strobe.

Function
REQ-017 The block SHALL sum 2^k consecutive valid I samples and, separately, 2^k consecutive valid Q samples into signed accumulators of WIDTH+MAX_LOG2_DECIM bits, with no intermediate overflow.
REQ-018 The block SHALL keep a window counter of MAX_LOG2_DECIM bits that increments only on i_valid and wraps to 0 after sample 2^k-1.
REQ-019 On the i_valid cycle carrying sample 2^k-1, the block SHALL register the complete sum (accumulator plus current sample) into stage A, clear the accumulator, and mark stage A valid.
REQ-020 One cycle after stage A, the block SHALL drive o_inph/o_quad = (sum + 2^(k-1)) >>> k (arithmetic shift, round half up); for k=0, o_inph/o_quad = sum.
REQ-021 The output SHALL be the low WIDTH bits of the rounded result, which always fits; no saturation logic SHALL exist.
REQ-022 Latency: o_valid SHALL assert exactly 2 cycles after the i_valid cycle of the last sample in the window, for one cycle.
REQ-023 o_inph/o_quad/oflow SHALL hold their last values while o_valid is low.
REQ-024 o_inph_oflow SHALL be the OR of i_inph_oflow over all samples of that window, and o_quad_oflow likewise for Q; both flags SHALL clear at each window start.
REQ-025 When i_log2_decim_valid is high, the block SHALL load k = min(i_log2_decim, MAX_LOG2_DECIM) and discard the partial window (counter, accumulators and sticky flags cleared).
REQ-026 When i_log2_decim_valid and i_valid are high in the same cycle, that sample SHALL be sample 0 of the new window under the new k.
REQ-027 A configuration load SHALL NOT cancel a result already in stage A; that result SHALL still emerge using the k it was accumulated with.
REQ-028 k SHALL be 0 out of reset (pass-through with 2-cycle latency).

Reset
REQ-029 While i_reset is high, all registers SHALL asynchronously clear: o_inph=0, o_quad=0, o_inph_oflow=0, o_quad_oflow=0, o_valid=0, k=0, counter=0, accumulators=0, stage A invalid.
REQ-030 Reset mid-window SHALL discard the partial window and produce no o_valid for it; the first window after release SHALL start at the first i_valid.

Verification
REQ-031 k=2, I=100,101,102,103 and Q=-1,-2,-3,-4 on consecutive cycles -> one o_valid 2 cycles after the 4th sample; o_inph=102, o_quad=-2.
REQ-032 k=0, I=-5, Q=7 -> o_inph=-5, o_quad=7 2 cycles later; every input produces one output.
REQ-033 k=4, 16 samples of I=-32768 with i_valid toggling every other cycle -> o_inph=-32768, exactly one o_valid.
REQ-034 k=2, i_inph_oflow high on the 2nd sample only -> o_inph_oflow=1, o_quad_oflow=0 for that window; the next window -> o_inph_oflow=0.
REQ-035 k=2, 2 samples in, then i_log2_decim=1 with i_log2_decim_valid and i_valid high together (I=10), then I=20 -> o_inph=15; the partial window produces no output.
REQ-036 k=1, reset asserted after 1 sample, released, then I=4,6 -> single output o_inph=5 with k=0 applied? No: k resets to 0, so the outputs are 4 and 6, each 2 cycles after its input.
